weight_fetch_unit: RTL and testbench

WEIGHT_FETCH_UNIT -- requirements
Module: weight_fetch_unit

---
 rtl/weight_fetch_unit_if.sv | 33 +++
 rtl/weight_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_weight_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_fetch_unit_if.sv
// Bundle for the weight fetch unit: job command, weight memory read port,
// systolic-array load port and compute-side tile handshake.
interface weight_fetch_unit_if;
    logic        instruction_i;
    logic [8:0]  H_DIM_i;
    logic [8:0]  W_DIM_i;
    logic [11:0] weight_start_addr_i;
    logic        next_weight_tile_i;
    logic [11:0] weight_mem_addr_o;
    logic        weight_mem_rd_o;
    logic        load_weights_o;
    logic [4:0]  weight_row_o;
    logic        weight_slot_o;
    logic        compute_weights_rdy_o;
    logic        compute_weights_buffered_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  state_dbg;

    modport master (
        output instruction_i, H_DIM_i, W_DIM_i, weight_start_addr_i, next_weight_tile_i,
        input  weight_mem_addr_o, weight_mem_rd_o, load_weights_o, weight_row_o,
        input  weight_slot_o, compute_weights_rdy_o, compute_weights_buffered_o,
        input  done_o, err_o, state_dbg
    );

    modport slave (
        input  instruction_i, H_DIM_i, W_DIM_i, weight_start_addr_i, next_weight_tile_i,
        output weight_mem_addr_o, weight_mem_rd_o, load_weights_o, weight_row_o,
        output weight_slot_o, compute_weights_rdy_o, compute_weights_buffered_o,
        output done_o, err_o, state_dbg
    );
endinterface

// File: rtl/weight_fetch_unit.sv
// Streams weight tiles (MUL_SIZE rows each) from weight memory into the systolic array slots.
// Define WEIGHT_PREFETCH_EN for double-buffering (two slots, next tile fetched during compute).
module weight_fetch_unit #(
    parameter int MUL_SIZE = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    weight_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        WAIT_SLOT = 2'd2,
        DRAIN     = 2'd3
    } state_t;

`ifdef WEIGHT_PREFETCH_EN
    localparam logic [1:0] SLOT_LIMIT = 2'd2;
`else
    localparam logic [1:0] SLOT_LIMIT = 2'd1;
`endif
    localparam logic [4:0] LAST_ROW = 5'(MUL_SIZE - 1);

    state_t      state, state_nxt;
    logic [8:0]  tiles_total;
    logic [8:0]  tile_idx;
    logic [8:0]  consumed;
    logic [11:0] base_addr;
    logic [4:0]  row;
    logic [1:0]  occ;
    logic [1:0]  alloc, alloc_nxt;
    logic        ld_v;
    logic [4:0]  ld_row;
    logic        err_q, done_q;
    logic        rd;
    logic [11:0] addr;

    logic start, row_last, tile_end, last_tile, consume, bad_consume, occ_inc, last_consume;

    // Handshake: compute_weights_rdy_o acts as valid (a loaded tile is held),
    // next_weight_tile_i is a one-cycle consume strobe; a strobe while nothing
    // is held is dropped and flagged on err_o.
    assign start        = (state == IDLE) && bus.instruction_i;
    assign row_last     = (row == LAST_ROW);
    assign tile_end     = (state == FETCH) && row_last;
    assign last_tile    = ((tile_idx + 9'd1) == tiles_total);
    assign consume      = bus.next_weight_tile_i && (occ != 2'd0);
    assign bad_consume  = bus.next_weight_tile_i && (occ == 2'd0);
    assign occ_inc      = ld_v && (ld_row == LAST_ROW);
    assign last_consume = consume && (consumed == (tiles_total - 9'd1));
    // alloc counts slots claimed from fetch completion until consumption, so
    // a tile still in the load pipeline already blocks its slot.
    assign alloc_nxt    = alloc + {1'b0, tile_end} - {1'b0, consume};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        addr      = 12'd0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                rd   = 1'b1;
                addr = base_addr + 12'(tile_idx * 9'(MUL_SIZE)) + {7'd0, row};
                if (row_last) begin
                    if (last_tile)                    state_nxt = DRAIN;
                    else if (alloc_nxt < SLOT_LIMIT)  state_nxt = FETCH;
                    else                              state_nxt = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (alloc_nxt < SLOT_LIMIT) state_nxt = FETCH;
            end
            DRAIN: begin
                if (last_consume) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tiles_total <= 9'd0;
            tile_idx    <= 9'd0;
            consumed    <= 9'd0;
            base_addr   <= 12'd0;
            row         <= 5'd0;
            occ         <= 2'd0;
            alloc       <= 2'd0;
            ld_v        <= 1'b0;
            ld_row      <= 5'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (start) begin
                tiles_total <= ({4'd0, bus.H_DIM_i[8:5]} + 9'd1) * ({4'd0, bus.W_DIM_i[8:5]} + 9'd1);
                base_addr   <= bus.weight_start_addr_i;
                tile_idx    <= 9'd0;
                row         <= 5'd0;
            end else if (state == FETCH) begin
                row <= row_last ? 5'd0 : row + 5'd1;
                if (row_last) tile_idx <= tile_idx + 9'd1;
            end
            if (start)        consumed <= 9'd0;
            else if (consume) consumed <= consumed + 9'd1;
            occ    <= occ + {1'b0, occ_inc} - {1'b0, consume};
            alloc  <= alloc_nxt;
            ld_v   <= rd;
            ld_row <= row;
            err_q  <= (err_q & ~start) | bad_consume;
            done_q <= (state == DRAIN) && last_consume;
        end
    end

`ifdef WEIGHT_PREFETCH_EN
    logic fetch_slot, ld_slot;

    // The slot written by the current fetch; the first tile of every job lands in slot 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_slot <= 1'b0;
            ld_slot    <= 1'b0;
        end else begin
            if (start)         fetch_slot <= 1'b0;
            else if (tile_end) fetch_slot <= ~fetch_slot;
            ld_slot <= fetch_slot;
        end
    end

    assign bus.weight_slot_o              = ld_slot;
    assign bus.compute_weights_buffered_o = (occ == 2'd2);
`else
    assign bus.weight_slot_o              = 1'b0;
    assign bus.compute_weights_buffered_o = 1'b0;
`endif

    assign bus.weight_mem_rd_o       = rd;
    assign bus.weight_mem_addr_o     = addr;
    assign bus.load_weights_o        = ld_v;
    assign bus.weight_row_o          = ld_row;
    assign bus.compute_weights_rdy_o = (occ != 2'd0);
    assign bus.done_o                = done_q;
    assign bus.err_o                 = err_q;
    assign bus.state_dbg             = state;
endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit; expectations follow the WEIGHT_PREFETCH_EN setting of the build.
module tb_weight_fetch_unit;
    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_FETCH = 32'd1;
    localparam logic [31:0] ST_WAIT  = 32'd2;
    localparam logic [31:0] ST_DRAIN = 32'd3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    weight_fetch_unit_if bus();

    weight_fetch_unit #(.MUL_SIZE(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [8:0] h, input logic [8:0] w, input logic [11:0] base);
        bus.H_DIM_i             = h;
        bus.W_DIM_i             = w;
        bus.weight_start_addr_i = base;
        bus.instruction_i       = 1'b1;
        tick();
        bus.instruction_i       = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next_weight_tile_i = 1'b1;
        tick();
        bus.next_weight_tile_i = 1'b0;
    endtask

    task automatic check_load(input string tag, input logic [4:0] row, input logic slot);
        check({tag, ":load"}, 32'(bus.load_weights_o), 32'd1);
        check({tag, ":row"},  32'(bus.weight_row_o), 32'(row));
        check({tag, ":slot"}, 32'(bus.weight_slot_o), 32'(slot));
    endtask

    // Entered with row 0 of the tile on the read port; returns one cycle after the last read.
    task automatic run_tile(input string tag, input logic [11:0] base, input logic slot);
        logic [11:0] exp_a;
        for (int r = 0; r < 32; r++) begin
            exp_a = base + 12'(r);
            check({tag, ":rd"},   32'(bus.weight_mem_rd_o), 32'd1);
            check({tag, ":addr"}, 32'(bus.weight_mem_addr_o), 32'(exp_a));
            if (r > 0) check_load(tag, 5'(r - 1), slot);
            tick();
        end
    endtask

    initial begin
        logic [11:0] wrap_addr [4];
        logic        slot_b;
        wrap_addr = '{12'hFC0, 12'hFE0, 12'h000, 12'h020};
`ifdef WEIGHT_PREFETCH_EN
        slot_b = 1'b1;
`else
        slot_b = 1'b0;
`endif
        bus.instruction_i       = 1'b0;
        bus.H_DIM_i             = 9'd0;
        bus.W_DIM_i             = 9'd0;
        bus.weight_start_addr_i = 12'd0;
        bus.next_weight_tile_i  = 1'b0;

        // Reset values.
        repeat (3) tick();
        check("rst:rd",    32'(bus.weight_mem_rd_o), 32'd0);
        check("rst:addr",  32'(bus.weight_mem_addr_o), 32'd0);
        check("rst:load",  32'(bus.load_weights_o), 32'd0);
        check("rst:row",   32'(bus.weight_row_o), 32'd0);
        check("rst:slot",  32'(bus.weight_slot_o), 32'd0);
        check("rst:rdy",   32'(bus.compute_weights_rdy_o), 32'd0);
        check("rst:buf",   32'(bus.compute_weights_buffered_o), 32'd0);
        check("rst:done",  32'(bus.done_o), 32'd0);
        check("rst:err",   32'(bus.err_o), 32'd0);
        check("rst:state", 32'(bus.state_dbg), ST_IDLE);

        // Single tile; instruction presented on the first cycle out of reset.
        rst_i = 1'b1;
        start_job(9'd31, 9'd31, 12'h100);
        check("t1:state", 32'(bus.state_dbg), ST_FETCH);
        run_tile("t1", 12'h100, 1'b0);
        check("t1:drain", 32'(bus.state_dbg), ST_DRAIN);
        check("t1:rd_end", 32'(bus.weight_mem_rd_o), 32'd0);
        check_load("t1:last", 5'd31, 1'b0);
        check("t1:rdy_early", 32'(bus.compute_weights_rdy_o), 32'd0);
        tick();
        check("t1:rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        check("t1:load_off", 32'(bus.load_weights_o), 32'd0);
        repeat (3) tick();
        check("t1:no_fetch", 32'(bus.weight_mem_rd_o), 32'd0);
        check("t1:done_early", 32'(bus.done_o), 32'd0);
        pulse_next();
        check("t1:done", 32'(bus.done_o), 32'd1);
        check("t1:idle", 32'(bus.state_dbg), ST_IDLE);
        check("t1:rdy_off", 32'(bus.compute_weights_rdy_o), 32'd0);
        tick();
        check("t1:done_pulse", 32'(bus.done_o), 32'd0);

        // Consume strobe with nothing loaded.
        pulse_next();
        check("err:set", 32'(bus.err_o), 32'd1);
        check("err:rdy", 32'(bus.compute_weights_rdy_o), 32'd0);
        check("err:state", 32'(bus.state_dbg), ST_IDLE);
        check("err:done", 32'(bus.done_o), 32'd0);
        repeat (2) tick();
        check("err:sticky", 32'(bus.err_o), 32'd1);

        // Two tiles stacked in y.
        start_job(9'd63, 9'd31, 12'h100);
        check("t2:err_clr", 32'(bus.err_o), 32'd0);
        run_tile("t2a", 12'h100, 1'b0);
        check_load("t2a:last", 5'd31, 1'b0);
`ifdef WEIGHT_PREFETCH_EN
        check("t2:prefetch", 32'(bus.state_dbg), ST_FETCH);
        run_tile("t2b", 12'h120, 1'b1);
        check("t2b:drain", 32'(bus.state_dbg), ST_DRAIN);
        check_load("t2b:last", 5'd31, 1'b1);
        tick();
        check("t2:buf", 32'(bus.compute_weights_buffered_o), 32'd1);
        check("t2:rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        pulse_next();
        check("t2:buf_drop", 32'(bus.compute_weights_buffered_o), 32'd0);
        check("t2:rdy_hold", 32'(bus.compute_weights_rdy_o), 32'd1);
        check("t2:done_early", 32'(bus.done_o), 32'd0);
        pulse_next();
        check("t2:done", 32'(bus.done_o), 32'd1);
`else
        check("t2:wait", 32'(bus.state_dbg), ST_WAIT);
        check("t2:rd_hold", 32'(bus.weight_mem_rd_o), 32'd0);
        tick();
        check("t2:rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        check("t2:buf", 32'(bus.compute_weights_buffered_o), 32'd0);
        repeat (2) tick();
        check("t2:still_wait", 32'(bus.state_dbg), ST_WAIT);
        check("t2:no_fetch", 32'(bus.weight_mem_rd_o), 32'd0);
        pulse_next();
        check("t2:rdy_off", 32'(bus.compute_weights_rdy_o), 32'd0);
        run_tile("t2b", 12'h120, 1'b0);
        check("t2b:drain", 32'(bus.state_dbg), ST_DRAIN);
        check_load("t2b:last", 5'd31, 1'b0);
        tick();
        check("t2:buf_b", 32'(bus.compute_weights_buffered_o), 32'd0);
        pulse_next();
        check("t2:done", 32'(bus.done_o), 32'd1);
`endif
        check("t2:idle", 32'(bus.state_dbg), ST_IDLE);
        tick();

        // 2x2 tiles; the base wraps through the 12-bit address space.
        start_job(9'd63, 9'd63, 12'hFC0);
`ifdef WEIGHT_PREFETCH_EN
        run_tile("t4a", wrap_addr[0], 1'b0);
        check_load("t4a:last", 5'd31, 1'b0);
        run_tile("t4b", wrap_addr[1], slot_b);
        check("t4:wait", 32'(bus.state_dbg), ST_WAIT);
        check_load("t4b:last", 5'd31, 1'b1);
        check("t4:rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        check("t4:buf0", 32'(bus.compute_weights_buffered_o), 32'd0);
        // Consume lands on the same cycle the second tile completes.
        pulse_next();
        check("t4:occ_same_rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        check("t4:occ_same_buf", 32'(bus.compute_weights_buffered_o), 32'd0);
        check("t4:err", 32'(bus.err_o), 32'd0);
        run_tile("t4c", wrap_addr[2], 1'b0);
        check("t4c:wait", 32'(bus.state_dbg), ST_WAIT);
        check_load("t4c:last", 5'd31, 1'b0);
        tick();
        check("t4:buf1", 32'(bus.compute_weights_buffered_o), 32'd1);
        pulse_next();
        check("t4:buf2", 32'(bus.compute_weights_buffered_o), 32'd0);
        run_tile("t4d", wrap_addr[3], 1'b1);
        check("t4d:drain", 32'(bus.state_dbg), ST_DRAIN);
        check_load("t4d:last", 5'd31, 1'b1);
        tick();
        check("t4:buf3", 32'(bus.compute_weights_buffered_o), 32'd1);
        pulse_next();
        check("t4:done_early", 32'(bus.done_o), 32'd0);
        pulse_next();
        check("t4:done", 32'(bus.done_o), 32'd1);
`else
        for (int t = 0; t < 4; t++) begin
            run_tile("t4", wrap_addr[t], 1'b0);
            check_load("t4:last", 5'd31, 1'b0);
            tick();
            check("t4:rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
            pulse_next();
            if (t < 3) check("t4:refetch", 32'(bus.state_dbg), ST_FETCH);
            else       check("t4:done", 32'(bus.done_o), 32'd1);
        end
`endif
        check("t4:idle", 32'(bus.state_dbg), ST_IDLE);
        tick();

        // Reset asserted at row 10 of the first tile.
        start_job(9'd31, 9'd31, 12'h040);
        repeat (10) tick();
        check("rst10:addr", 32'(bus.weight_mem_addr_o), 32'h04A);
        check_load("rst10:pre", 5'd9, 1'b0);
        rst_i = 1'b0;
        #1;
        check("rst10:rd",    32'(bus.weight_mem_rd_o), 32'd0);
        check("rst10:addr0", 32'(bus.weight_mem_addr_o), 32'd0);
        check("rst10:load",  32'(bus.load_weights_o), 32'd0);
        check("rst10:row",   32'(bus.weight_row_o), 32'd0);
        check("rst10:state", 32'(bus.state_dbg), ST_IDLE);
        tick();
        check("rst10:no_load", 32'(bus.load_weights_o), 32'd0);
        rst_i = 1'b1;
        start_job(9'd31, 9'd31, 12'h040);
        run_tile("t5", 12'h040, 1'b0);
        tick();
        check("t5:rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        pulse_next();
        check("t5:done", 32'(bus.done_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
